// File: rtl/codec_wb_arb_pkg.sv
// Shared types and constants for the codec Wishbone command arbiter.
// Imported by the arbiter top and its round-robin picker.
package codec_wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    localparam logic REQ_INIT = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/codec_wb_cmd_arbiter_rr.sv
// Combinational two-way round-robin picker.
// The registered last-grant index lives in the parent.
module rr_arbiter_2
    import codec_wb_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic       o_grant,
    output logic       o_any_valid
);

    assign o_any_valid = |i_valid;

    always_comb begin
        o_grant = REQ_INIT;
        if (i_valid[0] && i_valid[1]) begin
            o_grant = ~i_last_grant;
        end else if (i_valid[1]) begin
            o_grant = REQ_HOST;
        end
    end

endmodule

// File: rtl/codec_wb_cmd_arbiter.sv
// Two-port command arbiter in front of the codec Wishbone master.
// One command per grant; returns read data or a timeout error.
module codec_wb_cmd_arbiter
    import codec_wb_arb_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_resp_valid,
    output logic              req0_err,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_resp_valid,
    output logic              req1_err,

    output logic              mst_read,
    output logic              mst_write,
    output logic [ADDR_W-1:0] mst_address,
    output logic [DATA_W-1:0] mst_data_in,
    input  logic [DATA_W-1:0] mst_data_out,
    input  logic              mst_data_out_valid,
    input  logic              mst_done,

    output logic              busy,
    output logic              timeout_seen
);

    localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES);

    arb_state_t        r_state;
    logic              r_last_grant;
    logic              r_grant;
    logic [7:0]        r_cnt;

    logic              w_grant;
    logic              w_any;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;
    logic              w_limit;

    rr_arbiter_2 u_rr (
        .i_valid      ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_valid  (w_any)
    );

    assign w_we    = (w_grant == REQ_HOST) ? req1_we : req0_we;
    assign w_rdata = mst_data_out_valid ? mst_data_out : '0;
    assign w_limit = (r_cnt + 8'd1) == LP_LIMIT;
    assign busy    = (r_state != ARB_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ARB_IDLE;
            r_last_grant    <= REQ_HOST;
            r_grant         <= REQ_INIT;
            r_cnt           <= '0;
            req0_ready      <= 1'b0;
            req1_ready      <= 1'b0;
            req0_resp_valid <= 1'b0;
            req1_resp_valid <= 1'b0;
            req0_err        <= 1'b0;
            req1_err        <= 1'b0;
            req0_rdata      <= '0;
            req1_rdata      <= '0;
            mst_read        <= 1'b0;
            mst_write       <= 1'b0;
            mst_address     <= '0;
            mst_data_in     <= '0;
            timeout_seen    <= 1'b0;
        end else begin
            req0_ready      <= 1'b0;
            req1_ready      <= 1'b0;
            req0_resp_valid <= 1'b0;
            req1_resp_valid <= 1'b0;
            req0_err        <= 1'b0;
            req1_err        <= 1'b0;
            mst_read        <= 1'b0;
            mst_write       <= 1'b0;
            case (r_state)
                // RESP arbitrates on its way out so back-to-back commands
                // see the next grant sampled at the end of the RESP cycle.
                ARB_IDLE, ARB_RESP: begin
                    if (w_any) begin
                        r_state      <= ARB_WAIT;
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= '0;
                        req0_ready   <= (w_grant == REQ_INIT);
                        req1_ready   <= (w_grant == REQ_HOST);
                        mst_read     <= ~w_we;
                        mst_write    <= w_we;
                        if (w_grant == REQ_HOST) begin
                            mst_address <= req1_addr;
                            mst_data_in <= req1_wdata;
                        end else begin
                            mst_address <= req0_addr;
                            mst_data_in <= req0_wdata;
                        end
                    end else begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_WAIT: begin
                    if (mst_done) begin
                        r_state <= ARB_RESP;
                        if (r_grant == REQ_HOST) begin
                            req1_resp_valid <= 1'b1;
                            req1_rdata      <= w_rdata;
                        end else begin
                            req0_resp_valid <= 1'b1;
                            req0_rdata      <= w_rdata;
                        end
                    end else if (w_limit) begin
                        r_state      <= ARB_RESP;
                        timeout_seen <= 1'b1;
                        if (r_grant == REQ_HOST) begin
                            req1_resp_valid <= 1'b1;
                            req1_err        <= 1'b1;
                            req1_rdata      <= '0;
                        end else begin
                            req0_resp_valid <= 1'b1;
                            req0_err        <= 1'b1;
                            req0_rdata      <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
